// File: rtl/rr_seq_multiplier.sv
// Round-robin shared multiplier: one radix-2 shift-add product at a time for
// NUM_REQ requesters, returning a double-width result plus an overflow flag.
module rr_seq_multiplier #(
    parameter int WIDTH   = 64,
    parameter int NUM_REQ = 3,
    parameter int CNT_W   = $clog2(WIDTH + 1)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*WIDTH-1:0]   op_a,
    input  logic [NUM_REQ*WIDTH-1:0]   op_b,
    input  logic [NUM_REQ-1:0]         op_signed,
    input  logic [NUM_REQ-1:0]         ack_in,
    output logic [NUM_REQ-1:0]         grant,
    output logic [NUM_REQ-1:0]         ack_out,
    output logic                       working,
    output logic [2*WIDTH-1:0]         result,
    output logic                       overflow
);
    localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [OW-1:0]      rr_ptr_q, rr_ptr_d, owner_q, owner_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d, acc_q, acc_d, result_q, result_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sign_q, sign_d, signed_q, signed_d, overflow_q, overflow_d;
    logic [NUM_REQ-1:0] grant_q, grant_d, ack_q, ack_d;

    logic               found;
    logic [OW-1:0]      sel, cand;
    int                 idx;
    logic [WIDTH-1:0]   a_raw, b_raw, a_mag, b_mag;
    logic               s_sel, a_neg, b_neg;
    logic [2*WIDTH-1:0] prod;
    logic               ovf_calc;

    // First asserted request at or after rr_ptr, wrapping around.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        cand  = '0;
        idx   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(rr_ptr_q) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            cand = OW'(idx);
            if (!found && req[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    always_comb begin
        a_raw = op_a[sel*WIDTH +: WIDTH];
        b_raw = op_b[sel*WIDTH +: WIDTH];
        s_sel = op_signed[sel];
        a_neg = s_sel & a_raw[WIDTH-1];
        b_neg = s_sel & b_raw[WIDTH-1];
        a_mag = a_neg ? (~a_raw + 1'b1) : a_raw;
        b_mag = b_neg ? (~b_raw + 1'b1) : b_raw;
        prod  = sign_q ? (~acc_q + 1'b1) : acc_q;
        if (signed_q)
            ovf_calc = !((&prod[2*WIDTH-1:WIDTH-1]) || !(|prod[2*WIDTH-1:WIDTH-1]));
        else
            ovf_calc = |prod[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        sign_d     = sign_q;
        signed_d   = signed_q;
        result_d   = result_q;
        overflow_d = overflow_q;
        ack_d      = ack_q;
        grant_d    = '0;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    owner_d        = sel;
                    mcand_d        = {{WIDTH{1'b0}}, a_mag};
                    mplier_d       = b_mag;
                    acc_d          = '0;
                    cnt_d          = '0;
                    sign_d         = a_neg ^ b_neg;
                    signed_d       = s_sel;
                    grant_d[sel]   = 1'b1;
                    state_d        = S_BUSY;
                end
            end
            S_BUSY: begin
                if (cnt_q == CNT_W'(WIDTH)) begin
                    result_d       = prod;
                    overflow_d     = ovf_calc;
                    ack_d[owner_q] = 1'b1;
                    state_d        = S_DONE;
                end else begin
                    if (mplier_q[0]) acc_d = acc_q + mcand_q;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                if (ack_in[owner_q]) begin
                    ack_d      = '0;
                    result_d   = '0;
                    overflow_d = 1'b0;
                    rr_ptr_d   = (owner_q == OW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            sign_q     <= 1'b0;
            signed_q   <= 1'b0;
            result_q   <= '0;
            overflow_q <= 1'b0;
            ack_q      <= '0;
            grant_q    <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            sign_q     <= sign_d;
            signed_q   <= signed_d;
            result_q   <= result_d;
            overflow_q <= overflow_d;
            ack_q      <= ack_d;
            grant_q    <= grant_d;
        end
    end

    assign grant    = grant_q;
    assign ack_out  = ack_q;
    assign working  = (state_q != S_IDLE);
    assign result   = result_q;
    assign overflow = overflow_q;
endmodule
